// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its round-robin picker.
// Address/data widths fall back to small defaults when no global define is provided.
`ifndef ISIZE
`define ISIZE 8
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

package dmem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_e;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = P_CPU;
    if (req == 2'b11) begin
      winner = ~last;
    end else if (req[1]) begin
      winner = P_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port D_memory.
// Port 0 is the CPU load/store port, port 1 the debug/DMA port.
`ifndef ISIZE
`define ISIZE 8
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ISIZE  = `ISIZE,
  parameter int unsigned DSIZE  = `DSIZE,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [ISIZE-1:0] addr0,
  input  logic [DSIZE-1:0] wdata0,
  output logic             gnt0,
  output logic             rvalid0,
  output logic [DSIZE-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [ISIZE-1:0] addr1,
  input  logic [DSIZE-1:0] wdata1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [DSIZE-1:0] rdata1,
  output logic             mem_write_en,
  output logic [ISIZE-1:0] mem_address,
  output logic [DSIZE-1:0] mem_data_in,
  input  logic [DSIZE-1:0] mem_data_out
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic             we_q, we_d;
  logic [ISIZE-1:0] addr_q, addr_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [DSIZE-1:0] rdata0_q, rdata0_d;
  logic [DSIZE-1:0] rdata1_q, rdata1_d;

  logic             arb_valid;
  logic             arb_winner;
  logic             gnt_any;
  logic             sel_we;
  logic [ISIZE-1:0] sel_addr;
  logic [DSIZE-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req    ({req1, req0}),
    .last   (last_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  assign gnt_any   = |gnt_q;
  assign sel_we    = (arb_winner == P_DBG) ? we1    : we0;
  assign sel_addr  = (arb_winner == P_DBG) ? addr1  : addr0;
  assign sel_wdata = (arb_winner == P_DBG) ? wdata1 : wdata0;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        // The granted requester still holds req during its gnt cycle, so skip sampling then.
        if (arb_valid && !gnt_any) begin
          gnt_d[arb_winner] = 1'b1;
          we_d              = sel_we;
          addr_d            = sel_addr;
          wdata_d           = sel_wdata;
          last_d            = arb_winner;
          if (!sel_we) begin
            state_d = ST_RD_WAIT;
            owner_d = arb_winner;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_RD_WAIT: begin
        // Count starts once the memory has sampled the address (the cycle after gnt).
        if (!gnt_any) begin
          if (cnt_q == 2'd0) begin
            rvalid_d[owner_q] = 1'b1;
            if (owner_q == P_DBG) begin
              rdata1_d = mem_data_out;
            end else begin
              rdata0_d = mem_data_out;
            end
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= P_DBG;
      owner_q  <= P_CPU;
      cnt_q    <= 2'd0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign gnt0         = gnt_q[P_CPU];
  assign gnt1         = gnt_q[P_DBG];
  assign rvalid0      = rvalid_q[P_CPU];
  assign rvalid1      = rvalid_q[P_DBG];
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_write_en = we_q;
  assign mem_address  = addr_q;
  assign mem_data_in  = wdata_q;

endmodule
